mem_arbiter: RTL and testbench

Arbitrates one single-port unified memory between the instruction-fetch requester and the load/store requester of the core. Fetch and data requests issue through a req/gnt handshake. Read data returns one cycle after the grant. Data traffic has priority, and a starvation counter guarantees fetch progress. Misaligned accesses are caught and reported here before they reach memory.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// load/store. Data normally wins arbitration. A starvation counter forces a
// fetch grant after STARVE_LIMIT consecutive denied cycles. Misaligned accesses
// are still granted, but never reach memory, and complete with an error.
// Completion (rvalid/rdata/err) is returned one cycle after the grant.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch port
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_access_type,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  // memory port
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_access_type,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  // Access-width encoding shared with the core's ISA definitions.
  localparam logic [1:0] BYTE_MEM_ACCESS = 2'd0;
  localparam logic [1:0] HALF_MEM_ACCESS = 2'd1;
  localparam logic [1:0] WORD_MEM_ACCESS = 2'd2;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Request issued to memory in the grant cycle.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            atype;
    logic                  we;
  } req_t;

  // Completion record captured at the grant edge.
  typedef struct packed {
    logic owner;  // 1 = data port, 0 = fetch port
    logic err;    // access was misaligned
    logic rd;     // memory was read; rdata comes from mem_data_out
  } cpl_t;

  // Invalid access widths are treated as misaligned.
  function automatic logic is_aligned(input logic [1:0] atype, input logic [1:0] lsb);
    case (atype)
      BYTE_MEM_ACCESS: is_aligned = 1'b1;
      HALF_MEM_ACCESS: is_aligned = ~lsb[0];
      WORD_MEM_ACCESS: is_aligned = (lsb == 2'b00);
      default:         is_aligned = 1'b0;
    endcase
  endfunction

  logic [CW-1:0] starve_cnt;
  logic          fetch_pri;
  req_t          iss;
  logic          iss_ok;
  logic          any_gnt;
  logic [1:0]    vld_pipe;
  cpl_t          cpl_q;

  // Fetch takes priority only once it has been starved long enough.
  assign fetch_pri = (starve_cnt == LIMIT);
  assign if_gnt    = if_req & (~d_req | fetch_pri);
  assign d_gnt     = d_req & ~(if_req & fetch_pri);
  assign any_gnt   = if_gnt | d_gnt;

  // Select the granted request and check its alignment.
  always_comb begin
    iss    = '0;
    iss_ok = 1'b0;
    if (if_gnt) begin
      iss.addr  = if_addr;
      iss.atype = WORD_MEM_ACCESS;
      iss_ok    = is_aligned(WORD_MEM_ACCESS, if_addr[1:0]);
    end else if (d_gnt) begin
      iss.addr  = d_addr;
      iss.wdata = d_wdata;
      iss.atype = d_access_type;
      iss.we    = d_we;
      iss_ok    = is_aligned(d_access_type, d_addr[1:0]);
    end
  end

  // Misaligned grants keep the buses visible but suppress the strobes.
  assign mem_addr        = iss.addr;
  assign mem_data_in     = iss.wdata;
  assign mem_access_type = iss.atype;
  assign mem_read        = any_gnt & iss_ok & ~iss.we;
  assign mem_write       = any_gnt & iss_ok &  iss.we;

  // Count consecutive cycles where fetch asks but is refused, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    starve_cnt <= '0;
    else if (!if_req || if_gnt)    starve_cnt <= '0;
    else if (!fetch_pri)           starve_cnt <= starve_cnt + CW'(1);
  end

  // Stage 0 is the grant itself; stage 1 is the completion cycle.
  assign vld_pipe[0] = any_gnt;

  // Capture owner/error/read-type at each grant for next-cycle completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      cpl_q       <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      cpl_q       <= '{owner: d_gnt, err: ~iss_ok, rd: iss_ok & ~iss.we};
    end
  end

  // Route the completion to its owner; the other port stays quiet.
  assign if_rvalid = vld_pipe[1] & ~cpl_q.owner;
  assign d_rvalid  = vld_pipe[1] &  cpl_q.owner;
  assign if_err    = if_rvalid & cpl_q.err;
  assign d_err     = d_rvalid  & cpl_q.err;
  assign if_rdata  = (if_rvalid & cpl_q.rd) ? mem_data_out : '0;
  assign d_rdata   = (d_rvalid  & cpl_q.rd) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed test-plan steps followed by random
// traffic, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam logic [1:0] T_BYTE = 2'd0, T_HALF = 2'd1, T_WORD = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_addr, if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_addr, d_wdata, d_rdata;
  logic [1:0]    d_access_type, mem_access_type;
  logic [DW-1:0] mem_addr, mem_data_in, mem_data_out;
  logic          mem_read, mem_write;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: consecutive refused fetch cycles, and the pending completion
  int waited = 0;
  bit pv = 0, po = 0, perr = 0, prd = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_access_type(d_access_type), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_access_type(mem_access_type),
    .mem_data_out(mem_data_out)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 marks an invalid width.
  function automatic int size_of(input logic [1:0] t);
    return (t == T_BYTE) ? 1 : (t == T_HALF) ? 2 : (t == T_WORD) ? 4 : 0;
  endfunction

  function automatic bit aligned_ok(input logic [1:0] t, input logic [DW-1:0] a);
    int sz = size_of(t);
    if (sz == 0) return 0;
    return (a % sz) == 0;
  endfunction

  task automatic idle_inputs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_access_type = T_WORD;
  endtask

  // One clock cycle: check every output against the model, then advance it.
  // Entered just after a falling edge with inputs applied.
  task automatic tick(output bit g_if, output bit g_d);
    bit al;
    logic [DW-1:0] e_addr, e_din;
    logic [1:0] e_t;
    bit e_rd, e_wr;
    #1;
    g_if = if_req && (!d_req || waited == LIMIT);
    g_d  = d_req && !g_if;
    e_addr = '0; e_din = '0; e_t = 2'd0; e_rd = 0; e_wr = 0; al = 0;
    if (g_if) begin
      al = (if_addr % 4) == 0;
      e_addr = if_addr; e_t = T_WORD; e_rd = al;
    end else if (g_d) begin
      al = aligned_ok(d_access_type, d_addr);
      e_addr = d_addr; e_din = d_wdata; e_t = d_access_type;
      e_rd = al && !d_we; e_wr = al && d_we;
    end
    chk("if_gnt", if_gnt, g_if);
    chk("d_gnt", d_gnt, g_d);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_data_in", mem_data_in, e_din);
    chk("mem_access_type", mem_access_type, e_t);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("if_rvalid", if_rvalid, pv && !po);
    chk("if_err", if_err, pv && !po && perr);
    chk("if_rdata", if_rdata, (pv && !po && prd) ? mem_data_out : '0);
    chk("d_rvalid", d_rvalid, pv && po);
    chk("d_err", d_err, pv && po && perr);
    chk("d_rdata", d_rdata, (pv && po && prd) ? mem_data_out : '0);
    @(posedge clk);
    pv   = g_if || g_d;
    po   = g_d;
    perr = pv && !al;
    prd  = al && (g_if || (g_d && !d_we));
    if (if_req && !g_if) waited = (waited < LIMIT) ? waited + 1 : waited;
    else                 waited = 0;
    @(negedge clk);
    mem_data_out = $urandom;
  endtask

  // Reset with idle inputs; every output must read zero while it is held.
  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst_if_gnt", if_gnt, 0);       chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_if_err", if_err, 0);       chk("rst_d_err", d_err, 0);
    chk("rst_if_rdata", if_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_read", mem_read, 0);   chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_mem_type", mem_access_type, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    pv = 0; waited = 0;
  endtask

  initial begin
    bit gi, gd, ifp, dp;
    mem_data_out = 32'h1234_5678;
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
    do_reset();

    // Lone fetch: granted immediately, data returned next cycle.
    if_req = 1; if_addr = 32'h10;
    #1;
    chk("tp_if_gnt", if_gnt, 1); chk("tp_mem_read", mem_read, 1);
    chk("tp_mem_addr", mem_addr, 32'h10);
    tick(gi, gd);
    if_req = 0;
    #1;
    chk("tp_if_rvalid", if_rvalid, 1); chk("tp_if_rdata", if_rdata, mem_data_out);
    tick(gi, gd);

    // Simultaneous requests: data first, fetch next.
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h20; d_access_type = T_WORD;
    #1 chk("sim_d_first", d_gnt, 1);
    tick(gi, gd);
    d_req = 0;
    #1 chk("sim_if_second", if_gnt, 1);
    tick(gi, gd);
    if_req = 0;
    tick(gi, gd);

    // Starvation: data held continuously, fetch must win on cycle LIMIT+1.
    if_req = 1; if_addr = 32'h80;
    d_req = 1; d_we = 0; d_addr = 32'h24; d_access_type = T_WORD;
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk("starve_if_gnt", if_gnt, c == LIMIT + 1);
      chk("starve_d_gnt", d_gnt, c != LIMIT + 1);
      tick(gi, gd);
      if (gi) if_req = 0;
    end
    idle_inputs();
    tick(gi, gd);

    // Store handshake.
    d_req = 1; d_we = 1; d_addr = 32'h8; d_access_type = T_HALF; d_wdata = 32'hBEEF;
    #1;
    chk("st_mem_write", mem_write, 1); chk("st_type", mem_access_type, T_HALF);
    chk("st_data_in", mem_data_in, 32'hBEEF);
    tick(gi, gd);
    idle_inputs();
    #1;
    chk("st_rvalid", d_rvalid, 1); chk("st_err", d_err, 0); chk("st_rdata", d_rdata, 0);
    tick(gi, gd);

    // Misaligned word load.
    d_req = 1; d_we = 0; d_addr = 32'h6; d_access_type = T_WORD;
    #1;
    chk("mis_gnt", d_gnt, 1); chk("mis_mem_read", mem_read, 0);
    tick(gi, gd);
    idle_inputs();
    #1;
    chk("mis_rvalid", d_rvalid, 1); chk("mis_err", d_err, 1); chk("mis_rdata", d_rdata, 0);
    tick(gi, gd);

    // Reset right after a fetch grant: completion is dropped.
    if_req = 1; if_addr = 32'h100;
    tick(gi, gd);
    idle_inputs();
    rst_n = 0;
    #1 chk("rst_mid_if_rvalid", if_rvalid, 0);
    @(negedge clk);
    do_reset();

    // Build up starvation, reset, and confirm the count starts over.
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_addr = 32'h48; d_access_type = T_WORD;
    repeat (3) tick(gi, gd);
    do_reset();
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_addr = 32'h48; d_access_type = T_WORD;
    for (int c = 1; c <= LIMIT + 1; c++) begin
      #1 chk("rst_cnt_if_gnt", if_gnt, c == LIMIT + 1);
      tick(gi, gd);
    end
    idle_inputs();
    tick(gi, gd);

    // Random traffic; requests stay stable until granted, or are withdrawn.
    ifp = 0; dp = 0;
    for (int n = 0; n < 400; n++) begin
      if (ifp && ($urandom % 16) == 0) ifp = 0;
      if (dp && ($urandom % 16) == 0) dp = 0;
      if (!ifp && ($urandom % 3) == 0) begin
        ifp = 1;
        if_addr = $urandom & 32'hFFC;
        if (($urandom % 4) == 0) if_addr[1:0] = 2'($urandom);
      end
      if (!dp && ($urandom % 2) == 0) begin
        dp = 1;
        d_we = 1'($urandom);
        d_access_type = 2'($urandom);
        d_wdata = $urandom;
        d_addr = $urandom & 32'hFFC;
        if (($urandom % 3) == 0) d_addr[1:0] = 2'($urandom);
      end
      if_req = ifp; d_req = dp;
      tick(gi, gd);
      if (gi) ifp = 0;
      if (gd) dp = 0;
    end
    idle_inputs();
    tick(gi, gd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
